// File: rtl/sc_regbackg_shift_ctrl.sv
// sc_regbackg_shift_ctrl
// Control-side driver for a background-row register. It sequences game start
// (clear, then load), reloads on every level change and issues one-cycle
// rotate commands at a level-dependent rate.
// Optional feature macro: SC_REGBACKG_ALTDIR_EN. When it is defined, odd levels
// rotate opposite to even levels. When it is undefined, the direction is fixed
// by the DIRECTION parameter.
module sc_regbackg_shift_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int PERIOD_L0 = 400,
    parameter int PERIOD_L1 = 300,
    parameter int PERIOD_L2 = 200,
    parameter int PERIOD_L3 = 100,
    parameter int DIRECTION = 0
) (
    input  logic       SC_RegBACKGTYPE_CLOCK_50,
    input  logic       SC_RegBACKGTYPE_RESET_InHigh,
    input  logic       start_InLow,
    input  logic       pause_In,
    input  logic       level_up_In,
    output logic       clear_InLow,
    output logic       load_InLow,
    output logic [1:0] shiftselection_Out,
    output logic [1:0] transition_selector_Out,
    output logic [1:0] level_Out,
    output logic       busy_Out
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PER_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4
    } state_t;

    state_t             state_r, next_state_s;
    logic [1:0]         level_r, level_next_s;
    logic [PRE_W-1:0]   presc_r, presc_next_s;
    logic [PER_W-1:0]   per_r, per_next_s;
    logic [PER_W-1:0]   per_lim_s;
    logic [1:0]         shift_next_s;
    logic [1:0]         shift_r;
    logic               clear_r, load_r, busy_r;
    logic               dir_s;
    logic               shift_due_s;

    // Pick the shift period for the current level.
    always_comb begin
        per_lim_s = PER_W'(PERIOD_L0);
        case (level_r)
            2'd0:    per_lim_s = PER_W'(PERIOD_L0);
            2'd1:    per_lim_s = PER_W'(PERIOD_L1);
            2'd2:    per_lim_s = PER_W'(PERIOD_L2);
            2'd3:    per_lim_s = PER_W'(PERIOD_L3);
            default: per_lim_s = PER_W'(PERIOD_L0);
        endcase
    end

`ifdef SC_REGBACKG_ALTDIR_EN
    // Odd levels rotate opposite to even levels.
    assign dir_s = (DIRECTION != 0) ^ level_r[0];
`else
    assign dir_s = (DIRECTION != 0);
`endif

    // The decision is taken one cycle before the completing cycle, so the
    // registered pulse lands exactly on RUN cycle TICK_DIV*PERIOD.
    assign shift_due_s = (presc_r == PRE_W'(TICK_DIV - 2)) &&
                         (per_r == per_lim_s - PER_W'(1));

    // Next-state, level, counter and shift-command logic (start > level_up > pause > tick).
    always_comb begin
        next_state_s = state_r;
        level_next_s = level_r;
        presc_next_s = presc_r;
        per_next_s   = per_r;
        shift_next_s = 2'b00;
        case (state_r)
            IDLE, CLEAR, LOAD: begin
                presc_next_s = '0;
                per_next_s   = '0;
                if (!start_InLow) begin
                    next_state_s = CLEAR;
                    level_next_s = 2'd0;
                end else if (state_r == CLEAR) begin
                    next_state_s = LOAD;
                end else if (state_r == LOAD) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN, PAUSE: begin
                if (!start_InLow) begin
                    next_state_s = CLEAR;
                    level_next_s = 2'd0;
                    presc_next_s = '0;
                    per_next_s   = '0;
                end else if (level_up_In) begin
                    next_state_s = LOAD;
                    level_next_s = (level_r == 2'd3) ? 2'd3 : level_r + 2'd1;
                    presc_next_s = '0;
                    per_next_s   = '0;
                end else if (state_r == PAUSE) begin
                    // Counters hold while paused.
                    if (!pause_In) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = PAUSE;
                    end
                end else begin
                    // Every RUN cycle counts, even the one that sees pause.
                    if (presc_r == PRE_W'(TICK_DIV - 1)) begin
                        presc_next_s = '0;
                        if (per_r >= per_lim_s - PER_W'(1)) begin
                            per_next_s = '0;
                        end else begin
                            per_next_s = per_r + PER_W'(1);
                        end
                    end else begin
                        presc_next_s = presc_r + PRE_W'(1);
                    end
                    if (pause_In) begin
                        next_state_s = PAUSE;
                    end else if (shift_due_s) begin
                        shift_next_s = dir_s ? 2'b10 : 2'b01;
                    end else begin
                        shift_next_s = 2'b00;
                    end
                end
            end
            default: begin
                next_state_s = IDLE;
                level_next_s = 2'd0;
                presc_next_s = '0;
                per_next_s   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            state_r <= IDLE;
            level_r <= 2'd0;
            presc_r <= '0;
            per_r   <= '0;
            shift_r <= 2'b00;
            clear_r <= 1'b1;
            load_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            level_r <= level_next_s;
            presc_r <= presc_next_s;
            per_r   <= per_next_s;
            shift_r <= shift_next_s;
            clear_r <= (next_state_s != CLEAR);
            load_r  <= (next_state_s != LOAD);
            busy_r  <= (next_state_s != IDLE);
        end
    end

    assign clear_InLow             = clear_r;
    assign load_InLow              = load_r;
    assign shiftselection_Out      = shift_r;
    assign level_Out               = level_r;
    assign transition_selector_Out = level_r;
    assign busy_Out                = busy_r;

endmodule

// File: tb/tb_sc_regbackg_shift_ctrl.sv
// Directed bench for sc_regbackg_shift_ctrl with TICK_DIV=4, periods 4/3/2/1.
module tb_sc_regbackg_shift_ctrl;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       pause;
    logic       lvl_up;
    logic       clear_n, load_n, busy;
    logic [1:0] shift, tsel, level;
    logic [8:0] obs_s;
    int         errors;
    int         checks;

`ifdef SC_REGBACKG_ALTDIR_EN
    localparam logic [1:0] ODD_CODE = 2'b10;
`else
    localparam logic [1:0] ODD_CODE = 2'b01;
`endif

    sc_regbackg_shift_ctrl #(
        .TICK_DIV (4),
        .PERIOD_L0(4),
        .PERIOD_L1(3),
        .PERIOD_L2(2),
        .PERIOD_L3(1),
        .DIRECTION(0)
    ) dut (
        .SC_RegBACKGTYPE_CLOCK_50    (clk),
        .SC_RegBACKGTYPE_RESET_InHigh(rst),
        .start_InLow                 (start_n),
        .pause_In                    (pause),
        .level_up_In                 (lvl_up),
        .clear_InLow                 (clear_n),
        .load_InLow                  (load_n),
        .shiftselection_Out          (shift),
        .transition_selector_Out     (tsel),
        .level_Out                   (level),
        .busy_Out                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_s = {clear_n, load_n, shift, tsel, level, busy};

    function automatic logic [8:0] ev(input logic cl, input logic ld, input logic [1:0] sh,
                                      input logic [1:0] lv, input logic bz);
        return {cl, ld, sh, lv, lv, bz};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        checks++;
        assert (obs_s === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs_s, exp);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        start_n = 1'b1;
        pause   = 1'b0;
        lvl_up  = 1'b0;

        // Reset state
        step();
        chk("reset", ev(1'b1, 1'b1, 2'b00, 2'd0, 1'b0));
        rst = 1'b0;
        step();
        chk("idle", ev(1'b1, 1'b1, 2'b00, 2'd0, 1'b0));

        // 1. Start sequence and level-0 shifts every 16 cycles
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        chk("clear", ev(1'b0, 1'b1, 2'b00, 2'd0, 1'b1));
        step();
        chk("load", ev(1'b1, 1'b0, 2'b00, 2'd0, 1'b1));
        step();
        for (int k = 1; k <= 48; k++) begin
            chk($sformatf("l0_k%0d", k), ev(1'b1, 1'b1, (k % 16 == 0) ? 2'b01 : 2'b00, 2'd0, 1'b1));
            step();
        end

        // 2. level_up in RUN -> LOAD at level 1, shifts every 12 cycles
        lvl_up = 1'b1;
        step();
        lvl_up = 1'b0;
        chk("lu_load1", ev(1'b1, 1'b0, 2'b00, 2'd1, 1'b1));
        step();
        for (int k = 1; k <= 34; k++) begin
            chk($sformatf("l1_k%0d", k), ev(1'b1, 1'b1, (k % 12 == 0) ? ODD_CODE : 2'b00, 2'd1, 1'b1));
            step();
        end

        // 4a. level_up on the cycle that would complete the period: no pulse, LOAD next
        lvl_up = 1'b1;
        chk("l1_k35", ev(1'b1, 1'b1, 2'b00, 2'd1, 1'b1));
        step();
        lvl_up = 1'b0;
        chk("lu_on_tick", ev(1'b1, 1'b0, 2'b00, 2'd2, 1'b1));
        step();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("l2_k%0d", k), ev(1'b1, 1'b1, (k == 8) ? 2'b01 : 2'b00, 2'd2, 1'b1));
            step();
        end

        // 4b. start during RUN at level 2 -> CLEAR, level 0; level_up ignored in CLEAR/LOAD
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        chk("start_l2", ev(1'b0, 1'b1, 2'b00, 2'd0, 1'b1));
        lvl_up = 1'b1;
        step();
        chk("lu_in_clear", ev(1'b1, 1'b0, 2'b00, 2'd0, 1'b1));
        step();
        lvl_up = 1'b0;
        chk("lu_in_load", ev(1'b1, 1'b1, 2'b00, 2'd0, 1'b1));

        // 2b. Four level_up pulses saturate at level 3, still reloading
        for (int p = 1; p <= 4; p++) begin
            lvl_up = 1'b1;
            step();
            lvl_up = 1'b0;
            chk($sformatf("sat_p%0d", p), ev(1'b1, 1'b0, 2'b00, (p >= 3) ? 2'd3 : 2'(p), 1'b1));
            step();
        end
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("l3_k%0d", k), ev(1'b1, 1'b1, (k % 4 == 0) ? ODD_CODE : 2'b00, 2'd3, 1'b1));
            step();
        end

        // Restart from level 3, with start and level_up together (start wins)
        start_n = 1'b0;
        lvl_up  = 1'b1;
        step();
        start_n = 1'b1;
        lvl_up  = 1'b0;
        chk("start_l3", ev(1'b0, 1'b1, 2'b00, 2'd0, 1'b1));
        step();
        chk("reload0", ev(1'b1, 1'b0, 2'b00, 2'd0, 1'b1));
        step();

        // 3. Pause for 10 cycles from RUN cycle 10: first shift moves to cycle 26
        for (int k = 1; k <= 30; k++) begin
            pause = (k >= 10 && k <= 19);
            chk($sformatf("pause_k%0d", k), ev(1'b1, 1'b1, (k == 26) ? 2'b01 : 2'b00, 2'd0, 1'b1));
            step();
        end
        pause = 1'b0;

        // 5. Asynchronous reset during LOAD
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        step();
        chk("pre_rst_load", ev(1'b1, 1'b0, 2'b00, 2'd0, 1'b1));
        rst = 1'b1;
        #1;
        chk("async_rst", ev(1'b1, 1'b1, 2'b00, 2'd0, 1'b0));
        step();
        rst = 1'b0;
        step();
        lvl_up = 1'b1;
        pause  = 1'b1;
        step();
        lvl_up = 1'b0;
        pause  = 1'b0;
        chk("lu_idle", ev(1'b1, 1'b1, 2'b00, 2'd0, 1'b0));
        step();
        chk("idle_end", ev(1'b1, 1'b1, 2'b00, 2'd0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
